ram_access_ctrl: RTL
====================

# ram_access_ctrl

Synchronous access sequencer between the processor datapath and the asynchronous `RAMblock` memory. It takes one read or write request at a time over a valid/ready handshake and drives RAMblock's `address`, `datain`, `read` and `write` with fixed setup, strobe and hold phases. It registers `dataout` for reads and returns a one-cycle response. All RAM timing is owned by this block; the datapath never touches RAMblock pins directly.

## Interface
Parameters:
- `ADLINES`, 8: RAM address width; must match RAMblock.
- `DATALINES`, 16: RAM data width; must match RAMblock.
- `WR_CYCLES`, 4: number of clock cycles `ram_write` is held high. A value of 0 is treated as 1.
- `RD_CYCLES`, 2: number of clock cycles `ram_read` is held high before sampling. A value of 0 is treated as 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADLINES  request address.
- `req_wdata`  in  DATALINES  write data.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  DATALINES  read data; holds until the next sample.
- `rsp_err`  out  1  verify mismatch; constant 0 without the verify macro.
- `busy`  out  1  high in every state except IDLE.
- `ram_address`  out  ADLINES  to RAMblock `address`.
- `ram_datain`  out  DATALINES  to RAMblock `datain`.
- `ram_dataout`  in  DATALINES  from RAMblock `dataout`.
- `ram_read`  out  1  to RAMblock `read`.
- `ram_write`  out  1  to RAMblock `write`.

## Operation
- All outputs are registered.
- **Reset values:** FSM is IDLE; `req_ready`=1; every other output is 0.
- **Acceptance:** a request is accepted on a rising edge with `req_valid && req_ready`. At that edge `ram_address`←`req_addr` and `ram_datain`←`req_wdata`, and the opcode is latched. Both RAM buses stay frozen until the FSM returns to IDLE.
- **FSM states:** IDLE, SETUP, STROBE, HOLD, VSTROBE, VHOLD, RESP.
  - IDLE→SETUP on acceptance.
  - SETUP→STROBE after 1 cycle. Strobes are low in SETUP.
  - STROBE: `ram_write` (write) or `ram_read` (read) is held high for N cycles, where N = WR_CYCLES or RD_CYCLES. A down-counter of width ≥ clog2(N+1) tracks the cycles.
  - Reads: `rsp_rdata`←`ram_dataout` on the edge that ends the last STROBE cycle.
  - STROBE→HOLD. HOLD lasts 1 cycle with strobes low and buses still held.
  - HOLD→RESP. RESP lasts 1 cycle with `rsp_valid`=1.
  - RESP→IDLE.
- **Write responses:** `rsp_rdata` is unchanged by a write.
- **Strobe exclusivity:** `ram_read` and `ram_write` are never high in the same cycle.
- **Busy requests:** `req_valid` while busy is ignored, not queued. The requester must hold it until `req_ready`.
- **Reset mid-operation:** strobes drop immediately (asynchronous reset). The in-flight request is discarded with no `rsp_valid`, and the RAM contents are undefined for an interrupted write.

## Timing
Edge 0 is the acceptance edge.
- **Read:** `ram_read` is high from edge 1 to edge 1+RD_CYCLES. `rsp_rdata` is valid from edge 1+RD_CYCLES. `rsp_valid` is high from edge 2+RD_CYCLES to edge 3+RD_CYCLES. `req_ready` returns at edge 3+RD_CYCLES.
- **Write:** `ram_write` is high from edge 1 to edge 1+WR_CYCLES. `rsp_valid` is high from edge 2+WR_CYCLES to edge 3+WR_CYCLES.
- **Address/data hold:** address and data are stable for ≥1 cycle before and ≥1 cycle after every strobe.
- **Throughput:** minimum request spacing is N+4 cycles.

## Configuration
- `RAM_ACCESS_VERIFY_EN` defined:
  - After a write's HOLD, the FSM enters VSTROBE: `ram_read` is high for RD_CYCLES with the same address.
  - `ram_dataout` is sampled into `rsp_rdata`, and `rsp_err` = (sample ≠ written data).
  - Then VHOLD (1 cycle), then RESP.
  - Write response moves to edge 3+WR_CYCLES+RD_CYCLES.
  - `rsp_err` is valid only with `rsp_valid` and is 0 otherwise.
- `RAM_ACCESS_VERIFY_EN` undefined:
  - VSTROBE and VHOLD are absent.
  - `rsp_err` is tied to 0.
  - Write timing is as given in Timing.

## Test plan
- **Write:** write 10 to address 11 (WR_CYCLES=4) → `ram_write` is high exactly 4 cycles. `ram_address`=11 and `ram_datain`=10 are stable from edge 0 through HOLD. `rsp_valid` is a single pulse at edge 6.
- **Read-back:** read address 11 after the write → `ram_read` is high for 2 cycles, `rsp_rdata`=10, and `rsp_valid` pulses at edge 4.
- **Full-width data:** write 1003 to address 65, write 17 to address 19, then read 65, 19 and 0 → responses are 1003, 17, 0. `ram_read` and `ram_write` are never high together.
- **Busy:** hold `req_valid` with new operands throughout a busy write → exactly one transaction. The second is accepted only at the edge where `req_ready` returns. The RAM buses do not change mid-transaction.
- **Reset mid-operation:** assert `rst_n`=0 during the second write-strobe cycle → `ram_write` falls without waiting for a clock edge, there is no `rsp_valid`, all outputs hold reset values, and `req_ready`=1 after release.
- **Verify mode:** with `RAM_ACCESS_VERIFY_EN` defined and a RAM model whose bit 0 is stuck at 0, write 17 → `rsp_err`=1 and `rsp_rdata`=16 at edge 3+WR_CYCLES+RD_CYCLES. Writing 16 gives `rsp_err`=0.

Source files
------------

// File: rtl/ram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_access_ctrl
// Brief    : Single-outstanding read/write sequencer for the asynchronous
//            RAMblock with setup, strobe and hold phases. Define
//            RAM_ACCESS_VERIFY_EN to add a read-back verify after each write.
// Revision : 1.0
// ============================================================================
module ram_access_ctrl #(
    parameter int ADLINES   = 8,
    parameter int DATALINES = 16,
    parameter int WR_CYCLES = 4,
    parameter int RD_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADLINES-1:0]   req_addr,
    input  logic [DATALINES-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [DATALINES-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [ADLINES-1:0]   ram_address,
    output logic [DATALINES-1:0] ram_datain,
    input  logic [DATALINES-1:0] ram_dataout,
    output logic                 ram_read,
    output logic                 ram_write
);

    localparam int c_wr_n   = (WR_CYCLES < 1) ? 1 : WR_CYCLES;
    localparam int c_rd_n   = (RD_CYCLES < 1) ? 1 : RD_CYCLES;
    localparam int c_max_n  = (c_wr_n > c_rd_n) ? c_wr_n : c_rd_n;
    localparam int c_cnt_w  = $clog2(c_max_n + 1);
    localparam logic [c_cnt_w-1:0] c_wr_load = c_cnt_w'(c_wr_n - 1);
    localparam logic [c_cnt_w-1:0] c_rd_load = c_cnt_w'(c_rd_n - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_HOLD    = 3'd3,
        S_VSTROBE = 3'd4,
        S_VHOLD   = 3'd5,
        S_RESP    = 3'd6
    } state_t;

    state_t                 r_state, w_state_next;
    logic [c_cnt_w-1:0]     r_cnt, w_cnt_next;
    logic                   r_we;
    logic [ADLINES-1:0]     r_addr;
    logic [DATALINES-1:0]   r_wdata;
    logic [DATALINES-1:0]   r_rdata;
    logic                   r_rd, r_wr, r_rspv, r_ready, r_busy;
    logic                   w_sample, w_accept, w_rd_next, w_wr_next;

    assign w_accept = req_valid && r_ready;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_sample     = 1'b0;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_next = S_SETUP;
            S_SETUP: begin
                w_state_next = S_STROBE;
                w_cnt_next   = r_we ? c_wr_load : c_rd_load;
            end
            S_STROBE: begin
                if (r_cnt == '0) begin
                    w_state_next = S_HOLD;
                    w_sample     = !r_we;
                end else begin
                    w_cnt_next = r_cnt - c_cnt_one;
                end
            end
`ifdef RAM_ACCESS_VERIFY_EN
            S_HOLD: begin
                if (r_we) begin
                    w_state_next = S_VSTROBE;
                    w_cnt_next   = c_rd_load;
                end else begin
                    w_state_next = S_RESP;
                end
            end
            S_VSTROBE: begin
                if (r_cnt == '0) begin
                    w_state_next = S_VHOLD;
                    w_sample     = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - c_cnt_one;
                end
            end
            S_VHOLD:  w_state_next = S_RESP;
`else
            S_HOLD:   w_state_next = S_RESP;
`endif
            S_RESP:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they leave the flops glitch-free.
    assign w_wr_next = (w_state_next == S_STROBE) && r_we;
    assign w_rd_next = ((w_state_next == S_STROBE) && !r_we) || (w_state_next == S_VSTROBE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_rspv  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_sample) r_rdata <= ram_dataout;
            r_rd    <= w_rd_next;
            r_wr    <= w_wr_next;
            r_rspv  <= (w_state_next == S_RESP);
            r_ready <= (w_state_next == S_IDLE);
            r_busy  <= (w_state_next != S_IDLE);
        end
    end

`ifdef RAM_ACCESS_VERIFY_EN
    logic r_verr, r_err;

    // Mismatch is latched at the verify sample and only exposed during RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_verr <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_sample) r_verr <= r_we && (ram_dataout != r_wdata);
            r_err <= (w_state_next == S_RESP) && r_verr;
        end
    end

    assign rsp_err = r_err;
`else
    assign rsp_err = 1'b0;
`endif

    assign req_ready   = r_ready;
    assign busy        = r_busy;
    assign rsp_valid   = r_rspv;
    assign rsp_rdata   = r_rdata;
    assign ram_address = r_addr;
    assign ram_datain  = r_wdata;
    assign ram_read    = r_rd;
    assign ram_write   = r_wr;

endmodule
`default_nettype wire
